// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder: FSM state, debug view and a parameter
// legality check used at elaboration.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      state_t state;
      logic   sub;
      logic   carry;
   } dbg_t;

   function automatic bit chunking_ok(int width, int bpc);
      return (bpc > 0) && (width >= 2) && ((width % bpc) == 0);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the serial adder.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   // start is sampled only while busy=0; a/b/sub are captured with it and may
   // change afterwards. done pulses for one cycle; sum/cout/ovf then hold.
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/serial_adder_fa_slice.sv
// One-bit combinational full adder; chained to form the per-cycle ripple.
module fa_slice (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB chunk
// first, with a registered carry linking consecutive chunks.
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus,
   output dbg_t           dbg_o
);

   localparam int BPC   = BITS_PER_CYCLE;
   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);

   if (!chunking_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               sub_q, sub_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [BPC:0]       chain;
   logic [BPC-1:0]     slice_sum;
   logic [WIDTH-1:0]   sum_shift;

   assign chain[0] = carry_q;

   for (genvar i = 0; i < BPC; i++) begin : g_slice
      fa_slice u_fa (
         .x  (a_q[i]),
         .y  (b_q[i]),
         .ci (chain[i]),
         .s  (slice_sum[i]),
         .co (chain[i+1])
      );
   end

   // New chunk enters at the MSB end so the LSB chunk lands at bit 0 last.
   if (BPC == WIDTH) begin : g_single_step
      assign sum_shift = slice_sum;
   end else begin : g_multi_step
      assign sum_shift = {slice_sum, sum_q[WIDTH-1:BPC]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;
               sub_d   = bus.sub;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = sum_shift;
            a_d     = a_q >> BPC;
            b_d     = b_q >> BPC;
            carry_d = chain[BPC];
            cnt_d   = cnt_q + CNT_W'(1);
            // On the last chunk the top slice holds the operand MSBs.
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               cout_d  = chain[BPC];
               ovf_d   = chain[BPC-1] ^ chain[BPC];
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

   assign dbg_o.state = state_q;
   assign dbg_o.sub   = sub_q;
   assign dbg_o.carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: several parameter sets side by side, results
// checked against an arithmetic model through an expected-result queue.
module tb_serial_adder;
   import arith_pkg::*;

   localparam int N = 7;

   function automatic int ws(int g);
      return (g < 2) ? 8 : 16;
   endfunction

   function automatic int bs(int g);
      case (g)
         0: return 1;
         1: return 2;
         2: return 1;
         3: return 2;
         4: return 4;
         5: return 8;
         default: return 16;
      endcase
   endfunction

   // {ovf, cout, sum} for a w-bit add or two's-complement subtract.
   function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic s);
      logic [31:0] mask, aa, bb, tot;
      logic        co, ov;
      mask = (32'd1 << w) - 32'd1;
      aa   = {16'd0, a} & mask;
      bb   = {16'd0, (s ? ~b : b)} & mask;
      tot  = aa + bb + {31'd0, s};
      co   = tot[w];
      ov   = (aa[w-1] == bb[w-1]) && (tot[w-1] != aa[w-1]);
      return {ov, co, tot[15:0] & mask[15:0]};
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] start_v = '0;
   logic         sub_s = 1'b0;
   logic [15:0]  a_s = '0;
   logic [15:0]  b_s = '0;
   logic [N-1:0] busy_v, done_v, cout_v, ovf_v;
   logic [15:0]  sum_v [N];
   dbg_t         dbg_v [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int W = ws(g);
      serial_adder_if #(.WIDTH(W)) bus ();
      assign bus.start  = start_v[g];
      assign bus.sub    = sub_s;
      assign bus.a      = a_s[W-1:0];
      assign bus.b      = b_s[W-1:0];
      assign busy_v[g]  = bus.busy;
      assign done_v[g]  = bus.done;
      assign cout_v[g]  = bus.cout;
      assign ovf_v[g]   = bus.ovf;
      assign sum_v[g]   = 16'(bus.sum);
      serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(bs(g))) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus),
         .dbg_o (dbg_v[g])
      );
   end

   int          checks = 0;
   int          errors = 0;
   logic [17:0] exp_q[$];
   logic [17:0] mon_exp, mon_got;

   always @(negedge clk) begin
      for (int g = 0; g < N; g++) begin
         if (done_v[g] === 1'b1) begin
            checks++;
            mon_got = {ovf_v[g], cout_v[g], sum_v[g]};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done dut=%0d got=%h", g, mon_got);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_got !== mon_exp) begin
                  errors++;
                  $display("FAIL result dut=%0d got{ovf,cout,sum}=%h want=%h", g, mon_got, mon_exp);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one op on DUT g; returns cycles from accept edge to done and
   // the number of sampled cycles with busy high. Ends one cycle after done.
   task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b,
                         input logic s, output int lat, output int busy_cnt);
      start_v    = '0;
      start_v[g] = 1'b1;
      a_s   = a;
      b_s   = b;
      sub_s = s;
      exp_q.push_back(model(ws(g), a, b, s));
      tick();
      start_v = '0;
      a_s   = 16'($urandom);
      b_s   = 16'($urandom);
      sub_s = 1'($urandom);
      lat = 0;
      busy_cnt = 0;
      while (done_v[g] !== 1'b1 && lat < 64) begin
         if (busy_v[g] === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
      if (busy_v[g] === 1'b1) busy_cnt++;
      tick();
      checks++;
      if (done_v[g] !== 1'b0 || busy_v[g] !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse dut=%0d done=%b busy=%b want 0 0", g, done_v[g], busy_v[g]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      for (int g = 0; g < N; g++) begin
         checks++;
         if (busy_v[g] !== 1'b0 || done_v[g] !== 1'b0 || sum_v[g] !== 16'd0 ||
             cout_v[g] !== 1'b0 || ovf_v[g] !== 1'b0 || dbg_v[g].state !== IDLE) begin
            errors++;
            $display("FAIL reset_state dut=%0d busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     g, busy_v[g], done_v[g], sum_v[g], cout_v[g], ovf_v[g]);
         end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      logic [15:0] ta [3] = '{16'h35, 16'hFF, 16'h7F};
      logic [15:0] tb [3] = '{16'h4A, 16'h01, 16'h01};
      logic [17:0] e;
      int lat, bc;
      for (int i = 0; i < 3; i++) begin
         e = model(8, ta[i], tb[i], 1'b0);
         run_op(0, ta[i], tb[i], 1'b0, lat, bc);
         checks++;
         if (lat != 8 || bc != 9) begin
            errors++;
            $display("FAIL add_latency op=%0d lat=%0d busy=%0d want 8 9", i, lat, bc);
         end
         checks++;
         if (sum_v[0] !== e[15:0] || cout_v[0] !== e[16] || ovf_v[0] !== e[17]) begin
            errors++;
            $display("FAIL add_hold op=%0d sum=%h want %h", i, sum_v[0], e[15:0]);
         end
      end
   endtask

   task automatic test_sub();
      logic [15:0] ta [3] = '{16'h10, 16'h80, 16'h5A};
      logic [15:0] tb [3] = '{16'h20, 16'h01, 16'h00};
      int lat, bc;
      for (int i = 0; i < 3; i++) begin
         run_op(1, ta[i], tb[i], 1'b1, lat, bc);
         checks++;
         if (lat != 4 || bc != 5) begin
            errors++;
            $display("FAIL sub_latency op=%0d lat=%0d busy=%0d want 4 5", i, lat, bc);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic want;
      start_v = '0;
      start_v[0] = 1'b1;
      for (int c = 0; c < 30; c++) begin
         a_s   = 16'($urandom);
         b_s   = 16'($urandom);
         sub_s = 1'($urandom);
         if (c % 10 == 0) exp_q.push_back(model(8, a_s, b_s, sub_s));
         if (c == 29) begin
            tick();
            start_v = '0;
         end else begin
            tick();
         end
         want = (c % 10 == 8);
         checks++;
         if (done_v[0] !== want) begin
            errors++;
            $display("FAIL b2b_done cycle=%0d done=%b want %b", c, done_v[0], want);
         end
      end
      start_v = '0;
      tick();
      checks++;
      if (busy_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle busy=%b want 0", busy_v[0]);
      end
   endtask

   task automatic test_abort();
      int lat, bc;
      bit seen;
      run_op(0, 16'hFF, 16'h01, 1'b0, lat, bc);
      start_v[0] = 1'b1;
      a_s = 16'hFF;
      b_s = 16'h00;
      sub_s = 1'b0;
      tick();
      start_v = '0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (dbg_v[0].state !== RUN || busy_v[0] !== 1'b1 || cout_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre state=%0d busy=%b cout=%b want RUN 1 1",
                  dbg_v[0].state, busy_v[0], cout_v[0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || sum_v[0] !== 16'd0 ||
          cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_async busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                  busy_v[0], done_v[0], sum_v[0], cout_v[0], ovf_v[0]);
      end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_quiet activity seen after reset, want none");
      end
      run_op(0, 16'h12, 16'h34, 1'b0, lat, bc);
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL abort_recover lat=%0d want 8", lat);
      end
   endtask

   task automatic test_full_width();
      int lat, bc;
      run_op(6, 16'hFFFF, 16'h0001, 1'b0, lat, bc);
      checks++;
      if (lat != 1 || bc != 2) begin
         errors++;
         $display("FAIL full_width_latency lat=%0d busy=%0d want 1 2", lat, bc);
      end
   endtask

   task automatic test_random();
      int g, lat, bc;
      for (int i = 0; i < 40; i++) begin
         g = $urandom_range(0, N - 1);
         run_op(g, 16'($urandom), 16'($urandom), 1'($urandom), lat, bc);
         checks++;
         if (lat != ws(g) / bs(g)) begin
            errors++;
            $display("FAIL random_latency dut=%0d lat=%0d want %0d", g, lat, ws(g) / bs(g));
         end
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_abort();
      test_full_width();
      test_random();
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
